core_id_stage: RTL and testbench
================================

# core_id_stage

Instruction-decode stage of the RV32I core pipeline. It sits between the fetch stage and the register file / execute stage. It decodes the fetched instruction and drives the register-file read ports and read-latch control. It registers decoded control and immediate into the ID/EX pipeline slot, which lines up with the register file's registered read data, and detects load-use hazards so it can stall fetch and insert a bubble.

## Interface
Parameters:
- none (feature selection via macro only)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  fetch slot holds a valid instruction
- i_instr  in  32  instruction word from fetch (held stable by fetch while o_id_stall=1)
- i_pc  in  32  PC of i_instr
- i_stall  in  1  global pipeline freeze (bus wait downstream)
- i_flush  in  1  branch/jump redirect from EX; kill the instruction in ID
- o_id_stall  out  1  load-use hazard; fetch must hold its slot
- o_re1 / o_re2  out  1  regfile read enables
- o_raddr1 / o_raddr2  out  5  regfile read addresses (rs1 / rs2)
- o_rd_latch  out  1  regfile read-data hold
- o_ex_valid  out  1  ID/EX slot valid
- o_ex_pc  out  32  PC of EX instruction
- o_ex_imm  out  32  sign-extended immediate
- o_ex_rd  out  5  destination register
- o_ex_we  out  1  writes rd (forced 0 when rd=0)
- o_ex_alu_op  out  alu_op_t  ALU operation
- o_ex_funct3  out  3  load/store/branch size/condition
- o_ex_is_load / o_ex_is_store / o_ex_is_branch / o_ex_is_jal / o_ex_is_jalr  out  1  class flags
- o_ex_alu_src_imm  out  1  operand B is the immediate
- o_ex_alu_src_pc  out  1  operand A is the PC (AUIPC, JAL)
- o_ex_illegal  out  1  undecodable opcode/funct

## Operation
- Combinational decode of i_instr covers the R, I, S, B, U and J formats.
- o_re1 = i_valid and the format uses rs1; o_re2 = i_valid and the format uses rs2 (R, S, B). LUI, AUIPC and JAL drive re1=re2=0.
- Hazard: hz = i_valid && o_ex_valid && o_ex_is_load && o_ex_rd!=0 && ((o_re1 && o_raddr1==o_ex_rd) || (o_re2 && o_raddr2==o_ex_rd)).
- o_id_stall = hz && !i_flush. The stall output is combinational.
- o_rd_latch = i_stall. This is combinational.
- Edge priority for the ID/EX register: i_flush > i_stall > hz > normal.
  - flush: o_ex_valid<=0; other fields don't-care (hold).
  - stall: all o_ex_* hold.
  - hz: o_ex_valid<=0 (bubble); the instruction stays in ID, and its read is reissued next cycle with the forwarded load value.
  - normal: o_ex_* <= decode; o_ex_valid<=i_valid && !illegal_kill.
- Illegal instruction: o_ex_valid=1, o_ex_illegal=1, we=0, and all class flags 0.
- Immediate: I/S/B/U/J forms, sign-extended from bit 31. The B and J forms have bit0=0.
- FENCE decodes to a NOP (we=0, legal). ECALL/EBREAK decode as illegal.

## Timing
- Reset: every output register is 0, including o_ex_valid=0 and o_ex_alu_op=ALU_ADD (encoding 0).
- Latency: i_instr at edge N-1..N produces o_ex_* after edge N. This is aligned with the regfile o_rdata1/2 registered at the same edge.
- A load-use hazard costs exactly 1 bubble cycle. A second consecutive hazard cannot occur, because the bubble is not a load.
- Flush in the same cycle as hz: the flush wins, o_id_stall=0, and fetch advances to the redirect target.
- Stall in the same cycle as hz: the ID/EX slot holds and o_id_stall=1. Fetch is frozen regardless.
- Reset asserted mid-stall clears the slot immediately (asynchronously). The stall output falls because o_ex_valid=0.

## Configuration
- RV32M_EN defined: OP opcode with funct7=0000001 decodes to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM or ALU_REMU (by funct3); re1=re2=1, we=1.
- RV32M_EN undefined: the same encodings set o_ex_illegal=1 and we=0. The M enum members stay in the package so the enum encoding is stable.

## Structure
- core_pkg: alu_op_t enum, opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM, SYSTEM), funct7 constants.
- Sub-module core_imm_gen: purely combinational instr→imm, with a format select. It is instantiated once.

## Test plan
- ADDI x1,x2,5 (0x00510093), then NOPs:
  - o_re1=1, o_raddr1=2, o_re2=0.
  - Next cycle: o_ex_valid=1, rd=1, we=1, imm=5, alu_op=ALU_ADD, alu_src_imm=1.
- LW x5,0(x1) (0x0000A283) followed by ADD x6,x5,x0 (0x00028333):
  - o_id_stall=1 for exactly 1 cycle, and one o_ex_valid=0 bubble.
  - The ADD then enters EX with rd=6.
- JAL x1,-4 (0xFFDFF0EF):
  - imm=0xFFFFFFFC, is_jal=1, alu_src_pc=1, re1=re2=0.
- Load-use pair with i_flush asserted in the hazard cycle:
  - o_id_stall=0 and o_ex_valid=0.
  - No duplicate ADD afterwards.
- i_stall held for 3 cycles mid-stream:
  - o_rd_latch=1, and all o_ex_* are unchanged for those 3 cycles.
  - The stream resumes without loss or duplication.
- MUL x3,x1,x2 (0x022081B3):
  - With RV32M_EN: alu_op=ALU_MUL, we=1.
  - Without RV32M_EN: o_ex_illegal=1, we=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I decode types: ALU operations, immediate formats, opcodes and funct7 values.
// The M-extension ALU ops always exist here so the enum encoding is the same with or without RV32M_EN.
package core_pkg;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_PASSB  = 5'd10,
      ALU_MUL    = 5'd11,
      ALU_MULH   = 5'd12,
      ALU_MULHSU = 5'd13,
      ALU_MULHU  = 5'd14,
      ALU_DIV    = 5'd15,
      ALU_DIVU   = 5'd16,
      ALU_REM    = 5'd17,
      ALU_REMU   = 5'd18
   } alu_op_t;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_t;

   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] MISC_MEM = 7'b0001111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // funct3 -> ALU op for the base OP/OP_IMM group (shift-right variant resolved by the caller)
   function automatic alu_op_t base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic alu_op_t muldiv_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return ALU_MUL;
         3'b001:  return ALU_MULH;
         3'b010:  return ALU_MULHSU;
         3'b011:  return ALU_MULHU;
         3'b100:  return ALU_DIV;
         3'b101:  return ALU_DIVU;
         3'b110:  return ALU_REM;
         default: return ALU_REMU;
      endcase
   endfunction

endpackage

// File: rtl/core_id_stage_if.sv
// Fetch-side inputs and ID/EX-side outputs of the decode stage, bundled for the stage and its driver.
interface core_id_stage_if;
   import core_pkg::*;

   logic        i_valid;
   logic [31:0] i_instr;
   logic [31:0] i_pc;
   logic        i_stall;
   logic        i_flush;

   logic        o_id_stall;
   logic        o_re1;
   logic        o_re2;
   logic [4:0]  o_raddr1;
   logic [4:0]  o_raddr2;
   logic        o_rd_latch;
   logic        o_ex_valid;
   logic [31:0] o_ex_pc;
   logic [31:0] o_ex_imm;
   logic [4:0]  o_ex_rd;
   logic        o_ex_we;
   alu_op_t     o_ex_alu_op;
   logic [2:0]  o_ex_funct3;
   logic        o_ex_is_load;
   logic        o_ex_is_store;
   logic        o_ex_is_branch;
   logic        o_ex_is_jal;
   logic        o_ex_is_jalr;
   logic        o_ex_alu_src_imm;
   logic        o_ex_alu_src_pc;
   logic        o_ex_illegal;

   modport master (
      output i_valid, i_instr, i_pc, i_stall, i_flush,
      input  o_id_stall, o_re1, o_re2, o_raddr1, o_raddr2, o_rd_latch,
             o_ex_valid, o_ex_pc, o_ex_imm, o_ex_rd, o_ex_we, o_ex_alu_op, o_ex_funct3,
             o_ex_is_load, o_ex_is_store, o_ex_is_branch, o_ex_is_jal, o_ex_is_jalr,
             o_ex_alu_src_imm, o_ex_alu_src_pc, o_ex_illegal
   );

   modport slave (
      input  i_valid, i_instr, i_pc, i_stall, i_flush,
      output o_id_stall, o_re1, o_re2, o_raddr1, o_raddr2, o_rd_latch,
             o_ex_valid, o_ex_pc, o_ex_imm, o_ex_rd, o_ex_we, o_ex_alu_op, o_ex_funct3,
             o_ex_is_load, o_ex_is_store, o_ex_is_branch, o_ex_is_jal, o_ex_is_jalr,
             o_ex_alu_src_imm, o_ex_alu_src_pc, o_ex_illegal
   );

endinterface

// File: rtl/core_imm_gen.sv
// Combinational RV32I immediate extraction; every form sign-extends from instruction bit 31.
module core_imm_gen
   import core_pkg::*;
(
   input  logic [31:0] instr,
   input  imm_fmt_t    fmt,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (fmt)
         IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U: imm = {instr[31:12], 12'b0};
         IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/core_id_stage.sv
// RV32I decode stage: register-file read control, load-use hazard detection and the ID/EX slot.
// Define RV32M_EN to decode the M-extension multiply/divide group instead of trapping it as illegal.
module core_id_stage
   import core_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   core_id_stage_if.slave bus
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   imm_fmt_t    fmt;
   logic [31:0] dec_imm;
   alu_op_t     dec_alu;
   logic        use_rs1, use_rs2, dec_we, dec_illegal;
   logic        dec_load, dec_store, dec_branch, dec_jal, dec_jalr, dec_src_imm, dec_src_pc;
   logic        hz;

   assign opcode = bus.i_instr[6:0];
   assign funct3 = bus.i_instr[14:12];
   assign funct7 = bus.i_instr[31:25];

   core_imm_gen u_imm_gen (
      .instr (bus.i_instr),
      .fmt   (fmt),
      .imm   (dec_imm)
   );

   // Read enables follow the opcode's format; illegality only suppresses writeback and class flags.
   always_comb begin
      fmt         = IMM_NONE;
      dec_alu     = ALU_ADD;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      dec_we      = 1'b0;
      dec_illegal = 1'b0;
      dec_load    = 1'b0;
      dec_store   = 1'b0;
      dec_branch  = 1'b0;
      dec_jal     = 1'b0;
      dec_jalr    = 1'b0;
      dec_src_imm = 1'b0;
      dec_src_pc  = 1'b0;
      case (opcode)
         OP: begin
            use_rs1 = 1'b1;
            use_rs2 = 1'b1;
            dec_we  = 1'b1;
            if (funct7 == F7_BASE) dec_alu = base_op(funct3);
            else if (funct7 == F7_ALT && funct3 == 3'b000) dec_alu = ALU_SUB;
            else if (funct7 == F7_ALT && funct3 == 3'b101) dec_alu = ALU_SRA;
`ifdef RV32M_EN
            else if (funct7 == F7_MULDIV) dec_alu = muldiv_op(funct3);
            else dec_illegal = 1'b1;
`else
            else dec_illegal = 1'b1;
`endif
         end
         OP_IMM: begin
            fmt         = IMM_I;
            use_rs1     = 1'b1;
            dec_we      = 1'b1;
            dec_src_imm = 1'b1;
            dec_alu     = base_op(funct3);
            if (funct3 == 3'b001) dec_illegal = (funct7 != F7_BASE);
            else if (funct3 == 3'b101) begin
               if (funct7 == F7_ALT) dec_alu = ALU_SRA;
               else dec_illegal = (funct7 != F7_BASE);
            end
         end
         LOAD: begin
            fmt         = IMM_I;
            use_rs1     = 1'b1;
            dec_we      = 1'b1;
            dec_load    = 1'b1;
            dec_src_imm = 1'b1;
            dec_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
         end
         STORE: begin
            fmt         = IMM_S;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            dec_store   = 1'b1;
            dec_src_imm = 1'b1;
            dec_illegal = funct3[2] || (funct3 == 3'b011);
         end
         BRANCH: begin
            fmt         = IMM_B;
            use_rs1     = 1'b1;
            use_rs2     = 1'b1;
            dec_branch  = 1'b1;
            dec_illegal = (funct3[2:1] == 2'b01);
         end
         JAL: begin
            fmt         = IMM_J;
            dec_we      = 1'b1;
            dec_jal     = 1'b1;
            dec_src_imm = 1'b1;
            dec_src_pc  = 1'b1;
         end
         JALR: begin
            fmt         = IMM_I;
            use_rs1     = 1'b1;
            dec_we      = 1'b1;
            dec_jalr    = 1'b1;
            dec_src_imm = 1'b1;
            dec_illegal = (funct3 != 3'b000);
         end
         LUI: begin
            fmt         = IMM_U;
            dec_we      = 1'b1;
            dec_src_imm = 1'b1;
            dec_alu     = ALU_PASSB;
         end
         AUIPC: begin
            fmt         = IMM_U;
            dec_we      = 1'b1;
            dec_src_imm = 1'b1;
            dec_src_pc  = 1'b1;
         end
         MISC_MEM: begin
            fmt         = IMM_I;
            dec_illegal = (funct3 != 3'b000);
         end
         SYSTEM: begin
            fmt         = IMM_I;
            dec_illegal = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
      if (dec_illegal) begin
         dec_alu     = ALU_ADD;
         dec_we      = 1'b0;
         dec_load    = 1'b0;
         dec_store   = 1'b0;
         dec_branch  = 1'b0;
         dec_jal     = 1'b0;
         dec_jalr    = 1'b0;
         dec_src_imm = 1'b0;
         dec_src_pc  = 1'b0;
      end
   end

   assign bus.o_re1      = bus.i_valid && use_rs1;
   assign bus.o_re2      = bus.i_valid && use_rs2;
   assign bus.o_raddr1   = bus.i_instr[19:15];
   assign bus.o_raddr2   = bus.i_instr[24:20];
   assign bus.o_rd_latch = bus.i_stall;

   assign hz = bus.i_valid && bus.o_ex_valid && bus.o_ex_is_load && (bus.o_ex_rd != 5'd0) &&
               ((bus.o_re1 && (bus.o_raddr1 == bus.o_ex_rd)) ||
                (bus.o_re2 && (bus.o_raddr2 == bus.o_ex_rd)));
   assign bus.o_id_stall = hz && !bus.i_flush;

   // ID/EX slot: flush kills, freeze holds, load-use inserts a bubble, otherwise take the decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.o_ex_valid       <= 1'b0;
         bus.o_ex_pc          <= '0;
         bus.o_ex_imm         <= '0;
         bus.o_ex_rd          <= '0;
         bus.o_ex_we          <= 1'b0;
         bus.o_ex_alu_op      <= ALU_ADD;
         bus.o_ex_funct3      <= '0;
         bus.o_ex_is_load     <= 1'b0;
         bus.o_ex_is_store    <= 1'b0;
         bus.o_ex_is_branch   <= 1'b0;
         bus.o_ex_is_jal      <= 1'b0;
         bus.o_ex_is_jalr     <= 1'b0;
         bus.o_ex_alu_src_imm <= 1'b0;
         bus.o_ex_alu_src_pc  <= 1'b0;
         bus.o_ex_illegal     <= 1'b0;
      end else if (bus.i_flush) begin
         bus.o_ex_valid <= 1'b0;
      end else if (!bus.i_stall) begin
         if (hz) begin
            bus.o_ex_valid <= 1'b0;
         end else begin
            bus.o_ex_valid       <= bus.i_valid;
            bus.o_ex_pc          <= bus.i_pc;
            bus.o_ex_imm         <= dec_imm;
            bus.o_ex_rd          <= bus.i_instr[11:7];
            bus.o_ex_we          <= dec_we && (bus.i_instr[11:7] != 5'd0);
            bus.o_ex_alu_op      <= dec_alu;
            bus.o_ex_funct3      <= funct3;
            bus.o_ex_is_load     <= dec_load;
            bus.o_ex_is_store    <= dec_store;
            bus.o_ex_is_branch   <= dec_branch;
            bus.o_ex_is_jal      <= dec_jal;
            bus.o_ex_is_jalr     <= dec_jalr;
            bus.o_ex_alu_src_imm <= dec_src_imm;
            bus.o_ex_alu_src_pc  <= dec_src_pc;
            bus.o_ex_illegal     <= dec_illegal;
         end
      end
   end

endmodule

// File: tb/tb_core_id_stage.sv
// Scoreboard bench for core_id_stage: directed pipeline scenarios followed by random instruction streams.
// Honours RV32M_EN in the same way as the design when predicting multiply/divide encodings.
module tb_core_id_stage;
   import core_pkg::*;

`ifdef RV32M_EN
   localparam bit M_EN = 1'b1;
`else
   localparam bit M_EN = 1'b0;
`endif

   localparam logic [31:0] NOP_I = 32'h00000013;
   localparam logic [31:0] LW_I  = 32'h0000A283;
   localparam logic [31:0] ADD_I = 32'h00028333;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        we;
      alu_op_t     alu;
      logic [2:0]  f3;
      logic        ld, st, br, jal, jalr, src_imm, src_pc, ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   exp_t ex_m;
   exp_t sb[$];

   alu_op_t base_tab [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
   alu_op_t m_tab    [0:7] = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   logic [7:0] load_ok   = 8'b0011_0111;
   logic [7:0] store_ok  = 8'b0000_0111;
   logic [7:0] branch_ok = 8'b1111_0011;

   core_id_stage_if bus ();

   core_id_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic logic [31:0] imm_i(input logic [31:0] ins);
      int v;
      v = $signed(ins) >>> 20;
      return v;
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] ins);
      int hi;
      hi = $signed(ins) >>> 25;
      return hi * 32 + int'(ins[11:7]);
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] ins);
      int v;
      v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      return v;
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] ins);
      int v;
      v = (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      return v;
   endfunction

   function automatic logic uses1(input logic [31:0] ins);
      return ins[6:0] inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
   endfunction

   function automatic logic uses2(input logic [31:0] ins);
      return ins[6:0] inside {OP, STORE, BRANCH};
   endfunction

   function automatic exp_t idle_exp();
      exp_t e;
      e.valid = 1'b0; e.pc = '0; e.imm = '0; e.rd = '0; e.we = 1'b0; e.alu = ALU_ADD; e.f3 = '0;
      e.ld = 1'b0; e.st = 1'b0; e.br = 1'b0; e.jal = 1'b0; e.jalr = 1'b0;
      e.src_imm = 1'b0; e.src_pc = 1'b0; e.ill = 1'b0;
      return e;
   endfunction

   // What EX should hold after this instruction is accepted, derived from the ISA tables.
   function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      e = idle_exp();
      e.valid = 1'b1; e.pc = pc; e.rd = ins[11:7]; e.f3 = f3;
      case (ins[6:0])
         OP: begin
            e.we = 1'b1;
            if (f7 == 7'h00) e.alu = base_tab[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
            else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
            else if (f7 == 7'h01 && M_EN) e.alu = m_tab[f3];
            else e.ill = 1'b1;
         end
         OP_IMM: begin
            e.imm = imm_i(ins); e.we = 1'b1; e.src_imm = 1'b1;
            if (f3 == 3'd1) begin
               e.alu = ALU_SLL; e.ill = (f7 != 7'h00);
            end else if (f3 == 3'd5) begin
               e.alu = (f7 == 7'h20) ? ALU_SRA : ALU_SRL; e.ill = !(f7 == 7'h00 || f7 == 7'h20);
            end else e.alu = base_tab[f3];
         end
         LOAD:     begin e.imm = imm_i(ins); e.we = 1'b1; e.ld = 1'b1; e.src_imm = 1'b1; e.ill = !load_ok[f3]; end
         STORE:    begin e.imm = imm_s(ins); e.st = 1'b1; e.src_imm = 1'b1; e.ill = !store_ok[f3]; end
         BRANCH:   begin e.imm = imm_b(ins); e.br = 1'b1; e.ill = !branch_ok[f3]; end
         JAL:      begin e.imm = imm_j(ins); e.we = 1'b1; e.jal = 1'b1; e.src_imm = 1'b1; e.src_pc = 1'b1; end
         JALR:     begin e.imm = imm_i(ins); e.we = 1'b1; e.jalr = 1'b1; e.src_imm = 1'b1; e.ill = (f3 != 3'd0); end
         LUI:      begin e.imm = ins & 32'hFFFFF000; e.we = 1'b1; e.src_imm = 1'b1; e.alu = ALU_PASSB; end
         AUIPC:    begin e.imm = ins & 32'hFFFFF000; e.we = 1'b1; e.src_imm = 1'b1; e.src_pc = 1'b1; end
         MISC_MEM: begin e.imm = imm_i(ins); e.ill = (f3 != 3'd0); end
         SYSTEM:   begin e.imm = imm_i(ins); e.ill = 1'b1; end
         default:  e.ill = 1'b1;
      endcase
      if (e.ill) begin
         e.we = 1'b0; e.alu = ALU_ADD; e.ld = 1'b0; e.st = 1'b0; e.br = 1'b0;
         e.jal = 1'b0; e.jalr = 1'b0; e.src_imm = 1'b0; e.src_pc = 1'b0;
      end
      e.we = e.we && (e.rd != 5'd0);
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int k, s;
      r = $urandom;
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      k = $urandom_range(0, 13);
      case (k)
         0, 1: r[6:0] = OP_IMM;
         2: begin
            r[6:0] = OP; r[24:20] = 5'($urandom_range(0, 3)); s = $urandom_range(0, 3);
            r[31:25] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : (s == 2) ? 7'h01 : r[31:25];
         end
         3, 4: begin r[6:0] = LOAD; if ($urandom_range(0, 1) == 1) r[14:12] = 3'b010; end
         5:  begin r[6:0] = STORE;  r[24:20] = 5'($urandom_range(0, 3)); end
         6:  begin r[6:0] = BRANCH; r[24:20] = 5'($urandom_range(0, 3)); end
         7:  r[6:0] = JAL;
         8:  begin r[6:0] = JALR; if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000; end
         9:  r[6:0] = LUI;
         10: r[6:0] = AUIPC;
         11: begin r[6:0] = MISC_MEM; if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000; end
         12: r = ($urandom_range(0, 1) == 1) ? 32'h00100073 : 32'h00000073;
         13: begin r[6:0] = OP; r[31:25] = 7'h01; r[24:20] = 5'($urandom_range(0, 3)); end
         default: r = $urandom;
      endcase
      return r;
   endfunction

   // One fetch-slot cycle: drive inputs, check the combinational outputs, predict the next ID/EX state.
   task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                input logic st, input logic fl, output logic hz);
      @(negedge clk);
      bus.i_valid = v;
      bus.i_instr = ins;
      bus.i_pc    = pc;
      bus.i_stall = st;
      bus.i_flush = fl;
      #1;
      hz = v && ex_m.valid && ex_m.ld && (ex_m.rd != 5'd0) &&
           ((uses1(ins) && ins[19:15] == ex_m.rd) || (uses2(ins) && ins[24:20] == ex_m.rd));
      checkOutput("id_stall", bus.o_id_stall, hz && !fl);
      checkOutput("re1", bus.o_re1, v && uses1(ins));
      checkOutput("re2", bus.o_re2, v && uses2(ins));
      checkOutput("raddr1", bus.o_raddr1, ins[19:15]);
      checkOutput("raddr2", bus.o_raddr2, ins[24:20]);
      checkOutput("rd_latch", bus.o_rd_latch, st);
      if (fl) ex_m.valid = 1'b0;
      else if (!st) begin
         if (hz) ex_m.valid = 1'b0;
         else begin
            ex_m = ref_decode(ins, pc);
            ex_m.valid = v;
         end
      end
      sb.push_back(ex_m);
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every predicted slot state is compared just after the edge that should produce it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("ex_valid", bus.o_ex_valid, e.valid);
            if (e.valid) begin
               checkOutput("ex_pc", bus.o_ex_pc, e.pc);
               checkOutput("ex_imm", bus.o_ex_imm, e.imm);
               checkOutput("ex_rd", bus.o_ex_rd, e.rd);
               checkOutput("ex_we", bus.o_ex_we, e.we);
               checkOutput("ex_alu_op", bus.o_ex_alu_op, e.alu);
               checkOutput("ex_funct3", bus.o_ex_funct3, e.f3);
               checkOutput("ex_class", {bus.o_ex_is_load, bus.o_ex_is_store, bus.o_ex_is_branch,
                                        bus.o_ex_is_jal, bus.o_ex_is_jalr},
                           {e.ld, e.st, e.br, e.jal, e.jalr});
               checkOutput("ex_src_imm", bus.o_ex_alu_src_imm, e.src_imm);
               checkOutput("ex_src_pc", bus.o_ex_alu_src_pc, e.src_pc);
               checkOutput("ex_illegal", bus.o_ex_illegal, e.ill);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic        hz;
      logic [31:0] cur_ins, cur_pc;
      logic        cur_v, st, fl;
      total = 0;
      bad   = 0;
      ex_m  = idle_exp();
      rst_n = 1'b0;
      bus.i_valid = 1'b0; bus.i_instr = '0; bus.i_pc = '0; bus.i_stall = 1'b0; bus.i_flush = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset_ex_valid", bus.o_ex_valid, 0);
      checkOutput("reset_alu_op", bus.o_ex_alu_op, ALU_ADD);
      checkOutput("reset_ex_imm", bus.o_ex_imm, 0);
      checkOutput("reset_ex_pc", bus.o_ex_pc, 0);
      checkOutput("reset_id_stall", bus.o_id_stall, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADDI x1,x2,5
      applyStimulus(1'b1, 32'h00510093, 32'h100, 1'b0, 1'b0, hz);
      checkOutput("addi_re1", bus.o_re1, 1);
      checkOutput("addi_raddr1", bus.o_raddr1, 2);
      checkOutput("addi_re2", bus.o_re2, 0);
      waitEdge();
      checkOutput("addi_valid", bus.o_ex_valid, 1);
      checkOutput("addi_rd", bus.o_ex_rd, 1);
      checkOutput("addi_we", bus.o_ex_we, 1);
      checkOutput("addi_imm", bus.o_ex_imm, 5);
      checkOutput("addi_alu", bus.o_ex_alu_op, ALU_ADD);
      checkOutput("addi_src_imm", bus.o_ex_alu_src_imm, 1);
      applyStimulus(1'b1, NOP_I, 32'h104, 1'b0, 1'b0, hz);

      // Load-use: LW x5 then ADD x6,x5,x0 costs one bubble
      applyStimulus(1'b1, LW_I, 32'h108, 1'b0, 1'b0, hz);
      applyStimulus(1'b1, ADD_I, 32'h10C, 1'b0, 1'b0, hz);
      checkOutput("lu_stall_on", bus.o_id_stall, 1);
      waitEdge();
      checkOutput("lu_bubble", bus.o_ex_valid, 0);
      applyStimulus(1'b1, ADD_I, 32'h10C, 1'b0, 1'b0, hz);
      checkOutput("lu_stall_off", bus.o_id_stall, 0);
      waitEdge();
      checkOutput("lu_add_rd", bus.o_ex_rd, 6);
      checkOutput("lu_add_valid", bus.o_ex_valid, 1);

      // JAL x1,-4
      applyStimulus(1'b1, 32'hFFDFF0EF, 32'h110, 1'b0, 1'b0, hz);
      checkOutput("jal_re", {bus.o_re1, bus.o_re2}, 0);
      waitEdge();
      checkOutput("jal_imm", bus.o_ex_imm, 32'hFFFFFFFC);
      checkOutput("jal_is_jal", bus.o_ex_is_jal, 1);
      checkOutput("jal_src_pc", bus.o_ex_alu_src_pc, 1);

      // Load-use with flush in the hazard cycle
      applyStimulus(1'b1, NOP_I, 32'h200, 1'b0, 1'b0, hz);
      applyStimulus(1'b1, LW_I, 32'h204, 1'b0, 1'b0, hz);
      applyStimulus(1'b1, ADD_I, 32'h208, 1'b0, 1'b1, hz);
      checkOutput("flush_stall", bus.o_id_stall, 0);
      waitEdge();
      checkOutput("flush_valid", bus.o_ex_valid, 0);
      applyStimulus(1'b1, NOP_I, 32'h300, 1'b0, 1'b0, hz);
      waitEdge();
      checkOutput("flush_no_dup", bus.o_ex_pc, 32'h300);

      // Three-cycle freeze mid-stream
      applyStimulus(1'b1, 32'h00700113, 32'h304, 1'b0, 1'b0, hz);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h00900193, 32'h308, 1'b1, 1'b0, hz);
         checkOutput("freeze_rd_latch", bus.o_rd_latch, 1);
         waitEdge();
         checkOutput("freeze_imm_hold", bus.o_ex_imm, 7);
      end
      applyStimulus(1'b1, 32'h00900193, 32'h308, 1'b0, 1'b0, hz);
      waitEdge();
      checkOutput("freeze_resume_imm", bus.o_ex_imm, 9);

      // MUL x3,x1,x2
      applyStimulus(1'b1, 32'h022081B3, 32'h30C, 1'b0, 1'b0, hz);
      waitEdge();
`ifdef RV32M_EN
      checkOutput("mul_alu", bus.o_ex_alu_op, ALU_MUL);
      checkOutput("mul_we", bus.o_ex_we, 1);
`else
      checkOutput("mul_illegal", bus.o_ex_illegal, 1);
      checkOutput("mul_we", bus.o_ex_we, 0);
`endif

      // Random stream with freezes, redirects and bubbles
      cur_ins = rand_instr();
      cur_pc  = 32'h1000;
      cur_v   = 1'b1;
      for (int n = 0; n < 600; n++) begin
         st = ($urandom_range(0, 9) == 0);
         fl = !st && ($urandom_range(0, 11) == 0);
         applyStimulus(cur_v, cur_ins, cur_pc, st, fl, hz);
         if (fl || !(st || hz)) begin
            cur_ins = rand_instr();
            cur_pc  = fl ? {16'h0000, 14'($urandom), 2'b00} : cur_pc + 32'd4;
            cur_v   = ($urandom_range(0, 7) != 0);
         end
      end

      // Reset asserted while a load-use stall is pending under a freeze
      applyStimulus(1'b1, NOP_I, 32'h400, 1'b0, 1'b0, hz);
      applyStimulus(1'b1, LW_I, 32'h404, 1'b0, 1'b0, hz);
      waitEdge();
      @(negedge clk);
      bus.i_valid = 1'b1; bus.i_instr = ADD_I; bus.i_pc = 32'h408; bus.i_stall = 1'b1; bus.i_flush = 1'b0;
      #1;
      checkOutput("rst_pre_stall", bus.o_id_stall, 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rst_ex_valid", bus.o_ex_valid, 0);
      checkOutput("rst_id_stall", bus.o_id_stall, 0);
      checkOutput("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
